alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller plus two operands, and returns a registered result and a Zero flag.
- Single-cycle logic ops complete in one cycle. Shifts are iterative at one bit per clock, which keeps the barrel shifter off the critical path.
- Valid/ready handshakes on input and output let the pipeline control stall around multi-cycle shifts.

Parameters:
- WIDTH, 32, operand/result width in bits
- SHW, $clog2(WIDTH) = 5, shift-amount width taken from B[SHW-1:0]

Ports:
- clk  input  1  rising-edge clock, single domain
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request (high only in IDLE)
- Operation  input  4  ALU operation code from the ALU controller
- A  input  WIDTH  operand 1 (rs1)
- B  input  WIDTH  operand 2 (rs2 or immediate)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- ALUResult  output  WIDTH  registered result
- Zero  output  1  registered (ALUResult == 0), used for branch decisions
- IllegalOp  output  1  registered; high if the accepted Operation was not a defined code

Behaviour:
- Operation codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed, result 1 or 0)
  - 1100 XOR
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
  - All other codes are illegal.
- Reset (synchronous, reset=1 at a clk edge): state=IDLE; ALUResult=0, Zero=0, IllegalOp=0, out_valid=0; internal work register and count=0. Reset overrides every other input, including mid-shift: the in-flight op is dropped and no result is produced.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept: in_valid && in_ready at edge T.
  - Non-shift op: compute combinationally, register result/Zero/IllegalOp at T, go to DONE. out_valid is high in cycle T+1.
  - Illegal op: ALUResult=0, Zero=1, IllegalOp=1, go to DONE (latency 1).
  - Shift op: latch work=A, count=B[SHW-1:0], op kind.
    - If count==0: ALUResult=A, go to DONE.
    - Else: go to SHIFT.
- SHIFT: each cycle work shifts one bit (SLL: left, fill 0; SRL: right, fill 0; SRA: right, fill work[WIDTH-1]); count decrements. When count==1 on that edge, write the final shifted value to ALUResult/Zero and go to DONE.
  - Shift latency: out_valid first high in cycle T+1+shamt. Max shamt 31 gives 32 cycles.
- DONE: ALUResult/Zero/IllegalOp are held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE.
  - A new request cannot be accepted in the same cycle. Peak throughput is one op per 2 cycles.
- in_valid while busy (SHIFT/DONE): ignored. The upstream stage must hold the request until in_ready.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, with no carry or overflow outputs. SLT compares $signed(A) < $signed(B). Only B[SHW-1:0] is used for shifts; upper bits of B are ignored.
- IllegalOp clears on the next accepted legal op; it is not sticky.
- Operand/Operation inputs are sampled only at the accept edge. Later changes have no effect on an in-flight op.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the nine Operation codes (OP_AND … OP_SRA);
  - the FSM state enum (S_IDLE, S_SHIFT, S_DONE);
  - WIDTH default.
- One sub-module is natural: alu_comb_core, purely combinational. It takes Operation, A and B and returns result and illegal for the non-shift ops. The top holds the FSM, shift datapath and output registers.

Test Plan:
- Reset mid-SHIFT: SLL A=1, B=20; assert reset at cycle 5 -> next cycle in_ready=1, out_valid=0, ALUResult=0, no result emitted.
- ADD/SUB wrap: ADD A=32'hFFFF_FFFF, B=1 -> out_valid at T+1, ALUResult=0, Zero=1. SUB A=5, B=7 -> 32'hFFFF_FFFE, Zero=0.
- SLT signed: A=32'hFFFF_FFFF (-1), B=1 -> ALUResult=1. Swap operands -> ALUResult=0.
- Shifts and latency:
  - SRA A=32'h8000_0000, B=32'h0000_0024 (shamt 4) -> out_valid at T+5, ALUResult=32'hF800_0000.
  - SRL same operands -> 32'h0800_0000.
  - SLL A=3, B=0 -> out_valid at T+1, ALUResult=3.
- Backpressure: XOR A=32'hA5A5_A5A5, B=32'hFFFF_FFFF with out_ready=0 for 4 cycles -> ALUResult=32'h5A5A_5A5A held stable, in_ready=0, a second in_valid is ignored. After out_ready=1, in_ready=1 the following cycle.
- Illegal code: Operation=4'b0011 -> ALUResult=0, Zero=1, IllegalOp=1 at T+1. The next legal AND A=F0, B=3C -> 32'h30, IllegalOp=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
//   - Operation codes driven by the ALU controller
//   - FSM state type for the iterative-shift execution unit
//   - Default datapath width
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational core for the single-cycle ALU operations.
// Ports:
//   Operation - 4-bit ALU operation code
//   A, B      - operands
//   result    - result for AND/OR/ADD/SUB/SLT/XOR, zero otherwise
//   illegal   - high for codes that are not defined (shift codes are legal
//               here; the shift datapath lives in the top)
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (Operation)
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      OP_ADD: result = A + B;
      OP_SUB: result = A - B;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_XOR: result = A ^ B;
      OP_SLL, OP_SRL, OP_SRA: result = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes.
// Logic/arithmetic ops finish in one cycle; shifts iterate one bit per clock.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid / in_ready  - request handshake (in_ready high only in IDLE)
//   Operation, A, B      - operation code and operands, sampled at accept
//   out_valid / out_ready- result handshake (out_valid high only in DONE)
//   ALUResult, Zero      - registered result and (ALUResult == 0)
//   IllegalOp            - registered; accepted code was undefined
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             IllegalOp
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;
  logic [3:0]       shift_op;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] core_result;
  logic             core_illegal;
  logic             is_shift;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .Operation (Operation),
    .A         (A),
    .B         (B),
    .result    (core_result),
    .illegal   (core_illegal)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign is_shift  = (Operation == OP_SLL) || (Operation == OP_SRL) ||
                     (Operation == OP_SRA);

  // One-bit step of the latched shift kind applied to the work register.
  always_comb begin
    case (shift_op)
      OP_SLL:  shifted = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, work[WIDTH-1:1]};
      default: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ALUResult <= '0;
      Zero      <= 1'b0;
      IllegalOp <= 1'b0;
      work      <= '0;
      count     <= '0;
      shift_op  <= OP_SLL;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_shift) begin
              work      <= A;
              count     <= B[SHW-1:0];
              shift_op  <= Operation;
              IllegalOp <= 1'b0;
              // A zero shift amount completes immediately with A unchanged.
              if (B[SHW-1:0] == '0) begin
                ALUResult <= A;
                Zero      <= (A == '0);
                state     <= S_DONE;
              end else begin
                state <= S_SHIFT;
              end
            end else begin
              ALUResult <= core_result;
              Zero      <= (core_result == '0);
              IllegalOp <= core_illegal;
              state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          work  <= shifted;
          count <= count - SHW'(1);
          // Last step: publish the value being shifted in on this edge.
          if (count == SHW'(1)) begin
            ALUResult <= shifted;
            Zero      <= (shifted == '0);
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
